// File: rtl/sobel_edge_core.sv
// sobel_edge_core
//   Streaming 3x3 Sobel edge detector for the luma path. Two line buffers
//   supply the two rows above the incoming pixel. A 3x3 window is built with
//   the current pixel in the bottom-right corner. The gradient magnitude is
//   either |Gx|+|Gy| (MAG_MODE=0) or max(|Gx|,|Gy|) (MAG_MODE=1). It is
//   thresholded into a binary edge map and also output saturated to DW bits.
//   Every output lags its input by exactly 4 clocks.
//
// Ports
//   clk        pixel clock
//   rst        synchronous reset, active-high
//   din_vld    active-pixel strobe
//   din        luma pixel, DW bits
//   hsync_in   line sync, delay-matched to hsync_out
//   vsync_in   frame sync; a rising edge restarts the row count
//   threshold  edge threshold, DW+3 bits, compared (strictly) every cycle
//   dout_vld   din_vld delayed 4
//   dout_bin   EDGE_POL on an edge pixel, ~EDGE_POL otherwise
//   dout_mag   gradient magnitude saturated to 2**DW-1
//   hsync_out  hsync_in delayed 4
//   vsync_out  vsync_in delayed 4
module sobel_edge_core #(
  parameter int unsigned DW       = 8,
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned AW       = 10,
  parameter int unsigned MAG_MODE = 0,
  parameter bit          EDGE_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [DW+2:0] threshold,
  output logic          dout_vld,
  output logic          dout_bin,
  output logic [DW-1:0] dout_mag,
  output logic          hsync_out,
  output logic          vsync_out
);

  localparam int unsigned LBW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [AW:0] COL_LIM = (AW+1)'(IMG_W);

  logic          r_vld_d, r_vs_d;
  logic [AW-1:0] r_col;
  logic [1:0]    r_row;
  logic          w_fall, w_vs_rise, w_in_range, w_border;
  logic [1:0]    w_row;
  logic [LBW-1:0] w_addr;

  logic [DW-1:0] r_lb0 [IMG_W];  // row r-1
  logic [DW-1:0] r_lb1 [IMG_W];  // row r-2
  logic [DW-1:0] w_up1, w_up2;

  logic [DW-1:0] r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;
  logic          r_ok0;
  logic [2:0]    r_vld_p, r_hs_p, r_vs_p;
  logic [DW+1:0] r_gx_pos, r_gx_neg, r_gy_pos, r_gy_neg;
  logic [DW+1:0] r_ax, r_ay;
  logic [DW+2:0] w_g;
  logic [DW-1:0] w_mag;

  function automatic logic [DW+1:0] wsum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [DW+1:0] absdiff(input logic [DW+1:0] a, input logic [DW+1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // A vsync rise on a pixel cycle clears the row before the pixel uses it.
  always_comb begin
    w_fall     = r_vld_d & ~din_vld;
    w_vs_rise  = vsync_in & ~r_vs_d;
    w_row      = w_vs_rise ? 2'd0 : r_row;
    w_in_range = {1'b0, r_col} < COL_LIM;
    w_border   = (w_row < 2'd2) | (r_col < AW'(2)) | ~w_in_range;
    w_addr     = r_col[LBW-1:0];
    w_up1      = '0;
    w_up2      = '0;
    if (w_in_range) begin
      w_up1 = r_lb0[w_addr];
      w_up2 = r_lb1[w_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_d <= 1'b0;
      r_vs_d  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_vld_d <= din_vld;
      r_vs_d  <= vsync_in;
      if (w_fall)
        r_col <= '0;
      else if (din_vld && (r_col != '1))
        r_col <= r_col + AW'(1);
      if (w_vs_rise)
        r_row <= '0;
      else if (w_fall && (r_row != 2'd3))
        r_row <= r_row + 2'd1;
    end
  end

  // Line buffers are not reset; rows 0/1 are still written so row 2 can use them.
  always_ff @(posedge clk) begin
    if (!rst && din_vld && w_in_range) begin
      r_lb0[w_addr] <= din;
      r_lb1[w_addr] <= r_lb0[w_addr];
    end
  end

  // S0: window shift, only on valid pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_p11, r_p12, r_p13} <= '0;
      {r_p21, r_p22, r_p23} <= '0;
      {r_p31, r_p32, r_p33} <= '0;
      r_ok0   <= 1'b0;
      r_vld_p <= '0;
      r_hs_p  <= '0;
      r_vs_p  <= '0;
    end else begin
      if (din_vld) begin
        r_p11 <= r_p12; r_p12 <= r_p13; r_p13 <= w_up2;
        r_p21 <= r_p22; r_p22 <= r_p23; r_p23 <= w_up1;
        r_p31 <= r_p32; r_p32 <= r_p33; r_p33 <= din;
      end
      r_ok0   <= din_vld & ~w_border;
      r_vld_p <= {r_vld_p[1:0], din_vld};
      r_hs_p  <= {r_hs_p[1:0], hsync_in};
      r_vs_p  <= {r_vs_p[1:0], vsync_in};
    end
  end

  // S1 weighted sums (zeroed for border/idle slots), S2 absolute differences
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gx_pos <= '0;
      r_gx_neg <= '0;
      r_gy_pos <= '0;
      r_gy_neg <= '0;
      r_ax     <= '0;
      r_ay     <= '0;
    end else begin
      if (r_ok0) begin
        r_gx_pos <= wsum(r_p13, r_p23, r_p33);
        r_gx_neg <= wsum(r_p11, r_p21, r_p31);
        r_gy_pos <= wsum(r_p31, r_p32, r_p33);
        r_gy_neg <= wsum(r_p11, r_p12, r_p13);
      end else begin
        r_gx_pos <= '0;
        r_gx_neg <= '0;
        r_gy_pos <= '0;
        r_gy_neg <= '0;
      end
      r_ax <= absdiff(r_gx_pos, r_gx_neg);
      r_ay <= absdiff(r_gy_pos, r_gy_neg);
    end
  end

  // S3: norm, saturate, compare
  always_comb begin
    if (MAG_MODE != 0)
      w_g = {1'b0, (r_ax >= r_ay) ? r_ax : r_ay};
    else
      w_g = {1'b0, r_ax} + {1'b0, r_ay};
    w_mag = (|w_g[DW+2:DW]) ? '1 : w_g[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld  <= 1'b0;
      dout_bin  <= ~EDGE_POL;
      dout_mag  <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      dout_vld  <= r_vld_p[2];
      dout_bin  <= (r_vld_p[2] && (w_g > threshold)) ? EDGE_POL : ~EDGE_POL;
      dout_mag  <= w_mag;
      hsync_out <= r_hs_p[2];
      vsync_out <= r_vs_p[2];
    end
  end

endmodule

// File: tb/tb_sobel_edge_core.sv
// tb_sobel_edge_core
//   Drives frames of luma pixels into two instances (L1 norm / background 1,
//   max norm / background 0) and compares every output, every cycle, against
//   a frame-level reference that keeps whole stored lines per column.
module tb_sobel_edge_core;

  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_vld = 1'b0;
  logic [DW-1:0] din = '0;
  logic          hsync_in = 1'b0;
  logic          vsync_in = 1'b0;
  logic [DW+2:0] threshold = '0;

  logic          l1_vld, l1_bin, l1_hs, l1_vs;
  logic [DW-1:0] l1_mag;
  logic          mx_vld, mx_bin, mx_hs, mx_vs;
  logic [DW-1:0] mx_mag;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sobel_edge_core #(.DW(DW), .IMG_W(IMG_W), .AW(AW), .MAG_MODE(0), .EDGE_POL(1'b0)) u_dut_l1 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .threshold(threshold), .dout_vld(l1_vld), .dout_bin(l1_bin),
    .dout_mag(l1_mag), .hsync_out(l1_hs), .vsync_out(l1_vs));

  sobel_edge_core #(.DW(DW), .IMG_W(IMG_W), .AW(AW), .MAG_MODE(1), .EDGE_POL(1'b1)) u_dut_mx (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .threshold(threshold), .dout_vld(mx_vld), .dout_bin(mx_bin),
    .dout_mag(mx_mag), .hsync_out(mx_hs), .vsync_out(mx_vs));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cur [IMG_W];
  int m_l1  [IMG_W];   // latest stored line value per column
  int m_l2  [IMG_W];   // the one before it
  bit m_wr  [IMG_W];
  int m_col = 0, m_row = 0;
  bit m_pvld = 0, m_pvs = 0;
  bit pv [4], ph [4], ps [4];
  int pg0 [4], pg1 [4];
  bit live = 0;
  bit e_vld, e_hs, e_vs, e_bin0, e_bin1;
  int e_mag0, e_mag1;

  initial begin
    for (int i = 0; i < IMG_W; i++) begin
      m_cur[i] = 0; m_l1[i] = 0; m_l2[i] = 0; m_wr[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      pv[i] = 0; ph[i] = 0; ps[i] = 0; pg0[i] = 0; pg1[i] = 0;
    end
  end

  function automatic void commit_line();
    for (int i = 0; i < IMG_W; i++)
      if (m_wr[i]) begin
        m_l2[i] = m_l1[i];
        m_l1[i] = m_cur[i];
        m_wr[i] = 0;
      end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin
    int g0, g1, c, gx, gy, ax, ay, row_eff;
    bit rise, fall;
    if (rst) begin
      commit_line();
      m_col = 0; m_row = 0; m_pvld = 0; m_pvs = 0;
      for (int i = 0; i < 4; i++) begin
        pv[i] = 0; ph[i] = 0; ps[i] = 0; pg0[i] = 0; pg1[i] = 0;
      end
      live = 1;
    end else begin
      g0 = 0; g1 = 0;
      rise = vsync_in && !m_pvs;
      fall = !din_vld && m_pvld;
      row_eff = rise ? 0 : m_row;
      if (din_vld) begin
        c = m_col;
        if (c < IMG_W) begin
          m_cur[c] = int'(din);
          m_wr[c] = 1;
        end
        if (row_eff >= 2 && c >= 2 && c < IMG_W) begin
          gx = (m_l2[c] + 2*m_l1[c] + m_cur[c]) - (m_l2[c-2] + 2*m_l1[c-2] + m_cur[c-2]);
          gy = (m_cur[c-2] + 2*m_cur[c-1] + m_cur[c]) - (m_l2[c-2] + 2*m_l2[c-1] + m_l2[c]);
          ax = iabs(gx); ay = iabs(gy);
          g0 = ax + ay;
          g1 = (ax > ay) ? ax : ay;
        end
        if (m_col < (1 << AW) - 1) m_col++;
      end
      if (fall) begin
        commit_line();
        m_col = 0;
        if (m_row < 3) m_row++;
      end
      if (rise) m_row = 0;
      m_pvld = din_vld; m_pvs = vsync_in;
      for (int i = 3; i > 0; i--) begin
        pv[i] = pv[i-1]; ph[i] = ph[i-1]; ps[i] = ps[i-1]; pg0[i] = pg0[i-1]; pg1[i] = pg1[i-1];
      end
      pv[0] = din_vld; ph[0] = hsync_in; ps[0] = vsync_in; pg0[0] = g0; pg1[0] = g1;
    end
    e_vld  = pv[3];
    e_hs   = ph[3];
    e_vs   = ps[3];
    e_mag0 = (pg0[3] > 255) ? 255 : pg0[3];
    e_mag1 = (pg1[3] > 255) ? 255 : pg1[3];
    e_bin0 = (pv[3] && pg0[3] > int'(threshold)) ? 1'b0 : 1'b1;
    e_bin1 = (pv[3] && pg1[3] > int'(threshold)) ? 1'b1 : 1'b0;
  end

  always @(negedge clk) begin
    if (live) begin
      check("l1_vld", 32'(l1_vld), 32'(e_vld));
      check("l1_hsync", 32'(l1_hs), 32'(e_hs));
      check("l1_vsync", 32'(l1_vs), 32'(e_vs));
      check("l1_mag", 32'(l1_mag), 32'(e_mag0));
      check("l1_bin", 32'(l1_bin), 32'(e_bin0));
      check("mx_vld", 32'(mx_vld), 32'(e_vld));
      check("mx_hsync", 32'(mx_hs), 32'(e_hs));
      check("mx_vsync", 32'(mx_vs), 32'(e_vs));
      check("mx_mag", 32'(mx_mag), 32'(e_mag1));
      check("mx_bin", 32'(mx_bin), 32'(e_bin1));
    end
  end

  // ---------------- stimulus ----------------
  localparam int K_FLAT = 0, K_STEP = 1, K_POINT = 2, K_RAND = 3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int kind, input int r, input int c);
    case (kind)
      K_FLAT:  return 8'd100;
      K_STEP:  return (c < 4) ? 8'd0 : 8'd255;
      K_POINT: return (r == 0 && c == 0) ? 8'd255 : 8'd0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic idle(input int n);
    din_vld = 0;
    hsync_in = 0;
    repeat (n) begin
      din = 8'($urandom_range(0, 255));
      tick();
    end
  endtask

  task automatic send_line(input int kind, input int r, input int len, input int rst_at,
                           input bit vs_first);
    for (int c = 0; c < len; c++) begin
      din_vld  = 1;
      din      = pix(kind, r, c);
      rst      = (c == rst_at);
      vsync_in = vs_first && (c == 0);
      tick();
    end
    rst = 0;
    vsync_in = 0;
    din_vld = 0;
    hsync_in = 1;
    tick();
    tick();
    idle(2);
  endtask

  task automatic send_frame(input int kind, input int thr, input int long_row,
                            input int rst_line, input bit vs_with_pixel);
    threshold = 11'(thr);
    if (!vs_with_pixel) begin
      vsync_in = 1;
      tick();
      tick();
      vsync_in = 0;
      idle(2);
    end
    for (int r = 0; r < 8; r++)
      send_line(kind, r, (r == long_row) ? IMG_W + 4 : IMG_W, (r == rst_line) ? 4 : -1,
                vs_with_pixel && (r == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1;
    repeat (3) tick();
    rst = 0;
    idle(3);
    send_frame(K_FLAT, 0, -1, -1, 0);
    send_frame(K_STEP, 75, -1, -1, 0);
    send_frame(K_STEP, 1019, -1, -1, 0);
    send_frame(K_STEP, 1020, -1, -1, 0);
    send_frame(K_POINT, 0, -1, -1, 0);
    send_frame(K_RAND, 100, 3, -1, 0);
    send_frame(K_RAND, 200, -1, 3, 0);
    send_frame(K_RAND, 0, -1, -1, 1);
    send_frame(K_RAND, 2047, -1, -1, 0);
    for (int i = 0; i < 4; i++)
      send_frame(K_RAND, $urandom_range(0, 1100), -1, -1, 0);
    idle(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
